// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared widths and divider state encoding for the arithmetic datapath
package arith_pkg;

  localparam int DW = 12;
  localparam int VW = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/seq_divider_if.sv
// rtl/seq_divider_if.sv - request/result bundle between a divider client and seq_divider
interface seq_divider_if #(
  parameter int DW = arith_pkg::DW,
  parameter int VW = arith_pkg::VW
);

  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          busy;
  logic          done;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division step producing one quotient bit
module div_step #(
  parameter int VW = arith_pkg::VW
) (
  input  logic [VW-1:0] partial_rem,
  input  logic          next_bit,
  input  logic [VW-1:0] divisor,
  output logic [VW-1:0] new_rem,
  output logic          q_bit
);

  logic [VW:0] trial;
  logic [VW:0] diff;

  // One extra bit so the shifted-in remainder can exceed the divisor's range.
  assign trial   = {partial_rem, next_bit};
  assign diff    = trial - {1'b0, divisor};
  assign q_bit   = (trial >= {1'b0, divisor});
  assign new_rem = q_bit ? diff[VW-1:0] : trial[VW-1:0];

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - sequential restoring divider, one quotient bit per cycle, MSB first
module seq_divider
  import arith_pkg::*;
#(
  parameter int DW = arith_pkg::DW,
  parameter int VW = arith_pkg::VW
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_divider_if.slave bus
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  div_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [DW-1:0] dvd_q;
  logic [VW-1:0] dvs_q;
  logic [VW-1:0] prem_q;
  logic [DW-1:0] quo_q;
  logic [VW-1:0] rem_q;
  logic          dbz_q;

  logic          accept;
  logic          zero_div;
  logic [VW-1:0] new_rem;
  logic          q_bit;

  assign accept   = bus.start && (state_q != RUN);
  assign zero_div = (bus.divisor == '0);

  div_step #(.VW(VW)) u_step (
    .partial_rem (prem_q),
    .next_bit    (dvd_q[DW-1]),
    .divisor     (dvs_q),
    .new_rem     (new_rem),
    .q_bit       (q_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = zero_div ? DONE : RUN;
      RUN:     if (cnt_q == '0) state_d = DONE;
      DONE:    state_d = accept ? (zero_div ? DONE : RUN) : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // dvd_q doubles as the quotient accumulator: operand bits leave at the top
  // while quotient bits enter at the bottom, so after DW steps it holds q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      dvd_q  <= '0;
      dvs_q  <= '0;
      prem_q <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      dbz_q  <= 1'b0;
    end else if (accept) begin
      cnt_q  <= CW'(DW - 1);
      dvd_q  <= bus.dividend;
      dvs_q  <= bus.divisor;
      prem_q <= '0;
      if (zero_div) begin
        quo_q <= '1;
        rem_q <= bus.dividend[VW-1:0];
        dbz_q <= 1'b1;
      end
    end else if (state_q == RUN) begin
      cnt_q  <= cnt_q - 1'b1;
      dvd_q  <= {dvd_q[DW-2:0], q_bit};
      prem_q <= new_rem;
      if (cnt_q == '0) begin
        quo_q <= {dvd_q[DW-2:0], q_bit};
        rem_q <= new_rem;
        dbz_q <= 1'b0;
      end
    end
  end

  assign bus.busy        = (state_q == RUN);
  assign bus.done        = (state_q == DONE);
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - randomized self-checking bench for seq_divider against an arithmetic model
module tb_seq_divider;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  seq_divider_if bus ();

  seq_divider dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void ref_div(input int a, input int b, output int q, output int r);
    if (b == 0) begin
      q = 4095;
      r = a % 64;
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Called at a negedge; returns at the negedge of the done cycle.
  task automatic do_op(input int a, input int b, input bit junk, output int q_o, output int r_o);
    int eq, er, c, busy_cnt, exp_lat;
    bit seen;
    ref_div(a, b, eq, er);
    exp_lat = (b == 0) ? 1 : 13;
    bus.dividend = 12'(a);
    bus.divisor  = 6'(b);
    bus.start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    c = 1;
    busy_cnt = 0;
    seen = 1'b0;
    while (!seen && c <= 40) begin
      if (bus.done) begin
        seen = 1'b1;
      end else begin
        if (bus.busy) busy_cnt++;
        if (junk && c <= 11) begin
          bus.start    = 1'($urandom_range(0, 1));
          bus.dividend = 12'($urandom);
          bus.divisor  = 6'($urandom);
        end else begin
          bus.start = 1'b0;
        end
        @(negedge clk);
        c++;
      end
    end
    bus.start = 1'b0;
    chk("done_latency", c, exp_lat);
    chk("busy_cycles", busy_cnt, exp_lat - 1);
    chk("busy_at_done", bus.busy, 0);
    chk("quotient", bus.quotient, eq);
    chk("remainder", bus.remainder, er);
    chk("div_by_zero", bus.div_by_zero, (b == 0));
    q_o = int'(bus.quotient);
    r_o = int'(bus.remainder);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_q"}, bus.quotient, 0);
    chk({tag, "_r"}, bus.remainder, 0);
    chk({tag, "_dbz"}, bus.div_by_zero, 0);
  endtask

  int q, r;
  int edge_a[6] = '{0, 4095, 63, 1, 4094, 2048};
  int edge_b[6] = '{5, 0, 63, 63, 2, 1};

  initial begin
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    do_op(143, 11, 1'b0, q, r);
    chk("tp143_q", q, 13);
    chk("tp143_r", r, 0);
    @(negedge clk);
    do_op(4095, 63, 1'b0, q, r);
    chk("tp4095_63_q", q, 65);
    @(negedge clk);
    do_op(4095, 1, 1'b0, q, r);
    chk("tp4095_1_q", q, 4095);
    @(negedge clk);
    do_op(5, 7, 1'b0, q, r);
    chk("tp5_7_r", r, 5);
    do_op(100, 9, 1'b0, q, r);
    chk("b2b_q", q, 11);
    chk("b2b_r", r, 1);
    @(negedge clk);
    do_op(100, 0, 1'b0, q, r);
    chk("dbz_q", q, 4095);
    chk("dbz_r", r, 36);

    repeat (3) @(negedge clk);
    chk("hold_q", bus.quotient, 4095);
    chk("hold_dbz", bus.div_by_zero, 1);
    chk("hold_done", bus.done, 0);

    bus.dividend = 12'd200;
    bus.divisor  = 6'd3;
    bus.start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrun_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_op(200, 3, 1'b0, q, r);
    chk("after_reset_q", q, 66);
    chk("after_reset_r", r, 2);

    foreach (edge_a[i]) begin
      @(negedge clk);
      do_op(edge_a[i], edge_b[i], 1'b1, q, r);
    end

    for (int n = 0; n < 1000; n++) begin
      int a, b;
      a = int'($urandom_range(0, 4095));
      b = int'($urandom_range(1, 63));
      if ($urandom_range(0, 1) == 1) @(negedge clk);
      do_op(a, b, 1'($urandom_range(0, 1)), q, r);
      chk("mul_identity", q * b + r, a);
      chk("rem_lt_div", (r < b), 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
# seq_divider

Sequential restoring divider: the inverse of the team's combinational 6x6 array multiplier. It takes a 12-bit unsigned dividend and a 6-bit unsigned divisor, then produces a 12-bit quotient and a 6-bit remainder after a fixed number of cycles. It sits beside the multiplier in the arithmetic datapath. Together the two blocks satisfy `dividend == quotient*divisor + remainder`.

## Interface
Parameters:
- `DW`, default 12: dividend and quotient width.
- `VW`, default 6: divisor and remainder width.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: request a division; sampled only when `busy`=0.
- `dividend`, input, DW: unsigned dividend; captured when `start` is accepted.
- `divisor`, input, VW: unsigned divisor; captured when `start` is accepted.
- `busy`, output, 1: high while an operation is in progress.
- `done`, output, 1: one-cycle pulse when results are valid.
- `quotient`, output, DW: registered result, held until the next accepted start.
- `remainder`, output, VW: registered result, held until the next accepted start.
- `div_by_zero`, output, 1: registered flag, valid with `done`, held with the results.

## Operation
- States:
  - IDLE: `busy`=0.
  - RUN: `busy`=1.
  - DONE: `busy`=0, `done`=1.
- Start acceptance: `start` is accepted in IDLE or DONE.
  - Dividend and divisor are captured, iteration counter is set to DW-1, partial remainder is cleared.
  - Normal case: go to RUN.
  - If divisor==0: go to DONE directly with `quotient`=all ones, `remainder`=dividend[VW-1:0], `div_by_zero`=1.
- Start while in RUN is ignored and has no effect.
- RUN step, one quotient bit per cycle, MSB first:
  - Form `trial = {partial_rem, dividend[i]}`, VW+1 bits.
  - If `trial >= divisor`: `partial_rem = trial - divisor` and `q[i]=1`.
  - Otherwise `partial_rem = trial[VW-1:0]` and `q[i]=0`.
- Width rule: `partial_rem` is always < divisor, so VW bits suffice. The comparison and subtraction use VW+1 bits.
- Exit from RUN: after the step with i=0, go to DONE. `quotient`, `remainder` and `div_by_zero`(=0) update on that same edge.
- DONE lasts exactly one cycle, then IDLE, unless a start is accepted in DONE.
- Reset (asynchronous, any state, including mid-RUN):
  - State returns to IDLE.
  - `busy`, `done`, `quotient`, `remainder`, `div_by_zero` all clear to 0.
  - Internal registers clear to 0.
  - Any operation in progress is discarded.

## Timing
- Cycle 0: edge where `start` is accepted.
- Normal division:
  - `busy`=1 for cycles 1..DW (12 cycles).
  - `done`=1 in cycle DW+1; results are valid from that cycle on.
  - Latency from start edge to `done` is 13 cycles.
- Divide by zero: `done`=1 in cycle 1, `busy` never asserts.
- Back-to-back: a `start` accepted during DONE begins the next operation.
  - `done` falls the next cycle and `busy` rises.
  - Throughput is one result per 13 cycles.
- Outputs change only on accepted operation completion or on reset. There are no combinational paths from inputs to outputs.

## Structure
- Shared package `arith_pkg` holds:
  - the DW/VW width constants, shared with the multiplier;
  - the state enum {IDLE, RUN, DONE}.
- Sub-module `div_step`: combinational single restoring step.
  - Inputs: `partial_rem`, `next_bit`, `divisor`.
  - Outputs: `new_rem`, `q_bit`.
- `seq_divider` holds the FSM, counter, operand and result registers.

## Test plan
- 143 / 11 -> after 13 cycles: `done`=1, `quotient`=13, `remainder`=0, `div_by_zero`=0; `busy` is high for exactly 12 cycles.
- 4095 / 63 -> `quotient`=65, `remainder`=0; 4095 / 1 -> `quotient`=4095, `remainder`=0.
- 5 / 7 -> `quotient`=0, `remainder`=5; then a start in the DONE cycle with 100 / 9 -> `quotient`=11, `remainder`=1 exactly 13 cycles later.
- 100 / 0 -> `done` in cycle 1, `quotient`=4095, `remainder`=36, `div_by_zero`=1, `busy` never high.
- Start 200 / 3, assert `rst_n`=0 in cycle 5 -> all outputs 0 immediately, IDLE; a later start 200 / 3 yields 66 r 2 with normal timing.
- Start pulses during RUN ignored. A random sweep of 1000 operand pairs against the multiplier model must satisfy `q*d+r == dividend` with r < d.
